// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned EXC_W  = 5;
   localparam int unsigned PAGE_W = 20;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2,
      ST_FULL  = 2'd3
   } fetch_state_e;

   localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

   localparam logic [XLEN-1:0]   RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [XLEN-1:0]   HANDLER_PC_DEF = 32'h0000_4180;
   localparam logic [PAGE_W-1:0] TEXT_LO_DEF    = 20'h00003;
   localparam logic [PAGE_W-1:0] TEXT_HI_DEF    = 20'h00004;

   // Contents of the one-entry output buffer handed to ID.
   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  inst;
      logic [EXC_W-1:0] exc;
   } fetch_buf_t;

   function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Redirect detection, redirect target priority mux and fetch-address legality check.
module fetch_npc_sel
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0]   HANDLER_PC = HANDLER_PC_DEF,
   parameter logic [PAGE_W-1:0] TEXT_LO    = TEXT_LO_DEF,
   parameter logic [PAGE_W-1:0] TEXT_HI    = TEXT_HI_DEF
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic            eret_i,
   input  logic            flush_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] epc_i,
   input  logic [XLEN-1:0] br_target_i,
   output logic            redirect_o,
   output logic [XLEN-1:0] target_o,
   output logic            legal_o
);

   logic [PAGE_W-1:0] page;

   assign page = pc_i[XLEN-1:XLEN-PAGE_W];

   // ERET beats exception entry, which beats a branch.
   always_comb begin
      redirect_o = eret_i | flush_i | br_taken_i;
      target_o   = br_target_i;
      if (flush_i) target_o = HANDLER_PC;
      if (eret_i)  target_o = epc_i;
   end

   always_comb begin
      legal_o = (pc_i[1:0] == 2'b00) && (page >= TEXT_LO) && (page <= TEXT_HI);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: PC register, one-outstanding memory request and output buffer.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0]   RESET_PC   = RESET_PC_DEF,
   parameter logic [XLEN-1:0]   HANDLER_PC = HANDLER_PC_DEF,
   parameter logic [PAGE_W-1:0] TEXT_LO    = TEXT_LO_DEF,
   parameter logic [PAGE_W-1:0] TEXT_HI    = TEXT_HI_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             eret,
   input  logic [XLEN-1:0]  epc,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  br_target,
   output logic             mem_req,
   output logic [XLEN-1:0]  mem_addr,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             inst_valid,
   output logic [XLEN-1:0]  inst_pc,
   output logic [XLEN-1:0]  inst,
   output logic [EXC_W-1:0] exc_code,
   output logic             busy
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   fetch_buf_t      buf_q;
   logic            inst_valid_q;
   logic            busy_q;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            legal;

   fetch_npc_sel #(
      .HANDLER_PC (HANDLER_PC),
      .TEXT_LO    (TEXT_LO),
      .TEXT_HI    (TEXT_HI)
   ) u_npc_sel (
      .pc_i        (pc_q),
      .eret_i      (eret),
      .flush_i     (flush),
      .br_taken_i  (br_taken),
      .epc_i       (epc),
      .br_target_i (br_target),
      .redirect_o  (redirect),
      .target_o    (target),
      .legal_o     (legal)
   );

   // Request is held stable by the PC register until granted; suppressed on redirect.
   always_comb begin
      mem_req  = ~reset && (state_q == ST_ISSUE) && ~redirect && legal;
      mem_addr = pc_q;
   end

   assign inst_valid = inst_valid_q;
   assign inst_pc    = buf_q.pc;
   assign inst       = buf_q.inst;
   assign exc_code   = buf_q.exc;
   assign busy       = busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ISSUE;
         pc_q         <= RESET_PC;
         buf_q        <= '0;
         inst_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_ISSUE: begin
               if (redirect) begin
                  pc_q <= target;
               end else if (!legal) begin
                  // Bad fetch address is reported through the buffer, no memory access.
                  buf_q        <= '{pc: pc_q, inst: '0, exc: EXC_ADEL};
                  inst_valid_q <= 1'b1;
                  pc_q         <= pc_next_seq(pc_q);
                  state_q      <= ST_FULL;
               end else if (mem_gnt) begin
                  state_q <= ST_WAIT;
                  busy_q  <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (redirect) begin
                  pc_q <= target;
                  if (mem_rvalid) begin
                     state_q <= ST_ISSUE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_DROP;
                  end
               end else if (mem_rvalid) begin
                  buf_q        <= '{pc: pc_q, inst: mem_rdata, exc: EXC_NONE};
                  inst_valid_q <= 1'b1;
                  pc_q         <= pc_next_seq(pc_q);
                  state_q      <= ST_FULL;
                  busy_q       <= 1'b0;
               end
            end
            ST_DROP: begin
               if (redirect) pc_q <= target;
               if (mem_rvalid) begin
                  state_q <= ST_ISSUE;
                  busy_q  <= 1'b0;
               end
            end
            ST_FULL: begin
               if (redirect) begin
                  pc_q         <= target;
                  inst_valid_q <= 1'b0;
                  state_q      <= ST_ISSUE;
               end else if (!stall) begin
                  inst_valid_q <= 1'b0;
                  state_q      <= ST_ISSUE;
               end
            end
            default: begin
               state_q <= ST_ISSUE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
